qsys_conduit_to_avst_hw: RTL and testbench

- Upstream partner of the Qsys interface changer. Accepts a strobed conduit word from fabric logic and presents it as an Avalon-ST source (readyLatency 0) feeding the HPS/Qsys side.
- A small first-word-fall-through FIFO absorbs backpressure.
- A sticky overflow flag records words dropped while the FIFO was full.

---
 rtl/qsys_conduit_to_avst_hw.sv | 86 ++++++++
 tb/tb_qsys_conduit_to_avst_hw.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_conduit_to_avst_hw.sv
// Conduit-to-Avalon-ST bridge: strobed conduit words are queued in a small
// first-word-fall-through FIFO and presented as an Avalon-ST source with
// readyLatency 0. Words arriving while the FIFO is full (and nothing is
// leaving) are dropped and recorded in a sticky overflow flag.
module qsys_conduit_to_avst_hw #(
  parameter int WIDTH      = 1,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      sigIn,
  input  logic                  sigInValid,
  input  logic                  clearOverflow,
  output logic [WIDTH-1:0]      stData,
  output logic                  stValid,
  input  logic                  stReady,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fillLevel
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic w_empty;
  logic w_full;
  logic w_read;
  logic w_write;
  logic w_drop;

  // Handshake decode; all terms derive from registered state plus inputs,
  // so no input ever reaches stData/stValid combinationally.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    w_read  = !w_empty && stReady;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    w_write = sigInValid && (!w_full || w_read);
    w_drop  = sigInValid && w_full && !w_read;
  end

  // Storage write; held off during reset so a reset-cycle transfer leaves no trace.
  always_ff @(posedge clock) begin
    if (reset && w_write) begin
      r_mem[r_wr_ptr] <= sigIn;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_write) - CW'(w_read);
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clearOverflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Output mapping; data is forced to zero while nothing is valid.
  always_comb begin
    stValid   = !w_empty;
    stData    = w_empty ? '0 : r_mem[r_rd_ptr];
    overflow  = r_overflow;
    fillLevel = r_count;
  end

endmodule

// File: tb/tb_qsys_conduit_to_avst_hw.sv
// Directed self-checking bench for qsys_conduit_to_avst_hw (WIDTH=8, depth 4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_qsys_conduit_to_avst_hw;

  logic       clock;
  logic       reset;
  logic [7:0] sigIn;
  logic       sigInValid;
  logic       clearOverflow;
  logic [7:0] stData;
  logic       stValid;
  logic       stReady;
  logic       overflow;
  logic [2:0] fillLevel;

  int checks;
  int errors;

  qsys_conduit_to_avst_hw #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clock(clock),
    .reset(reset),
    .sigIn(sigIn),
    .sigInValid(sigInValid),
    .clearOverflow(clearOverflow),
    .stData(stData),
    .stValid(stValid),
    .stReady(stReady),
    .overflow(overflow),
    .fillLevel(fillLevel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sigInValid = 1'b1; sigIn = 8'h01; stReady = 1'b0; clearOverflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (stValid !== 1'b0 || fillLevel !== 3'd0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: stValid=%b fill=%0d ovf=%b, want 0/0/0", i, stValid, fillLevel, overflow);
      end
    end
    reset = 1'b1; sigInValid = 1'b0;
    step();
    checks++;
    if (stValid !== 1'b0 || fillLevel !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: stValid=%b fill=%0d ovf=%b, want 0/0/0", stValid, fillLevel, overflow);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    sigIn = 8'hA5; sigInValid = 1'b1; stReady = 1'b1;
    step();
    sigInValid = 1'b0;
    checks++;
    if (stValid !== 1'b1 || stData !== 8'hA5 || fillLevel !== 3'd1) begin
      errors++;
      $display("FAIL single_present: stValid=%b data=%h fill=%0d, want 1/a5/1", stValid, stData, fillLevel);
    end
    step();
    checks++;
    if (stValid !== 1'b0 || fillLevel !== 3'd0) begin
      errors++;
      $display("FAIL single_consumed: stValid=%b fill=%0d, want 0/0", stValid, fillLevel);
    end
    $display("test_single done");
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_fill [6];
    exp_fill = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    stReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sigIn = 8'(i + 1); sigInValid = 1'b1;
      step();
      checks++;
      if (fillLevel !== exp_fill[i] || overflow !== (i >= 4)) begin
        errors++;
        $display("FAIL bp_fill w%0d: fill=%0d ovf=%b, want %0d/%b", i + 1, fillLevel, overflow, exp_fill[i], (i >= 4));
      end
    end
    sigInValid = 1'b0; stReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (stValid !== 1'b1 || stData !== 8'(k + 1)) begin
        errors++;
        $display("FAIL bp_drain %0d: stValid=%b data=%h, want 1/%h", k, stValid, stData, 8'(k + 1));
      end
      step();
    end
    checks++;
    if (stValid !== 1'b0 || fillLevel !== 3'd0) begin
      errors++;
      $display("FAIL bp_empty: stValid=%b fill=%0d, want 0/0", stValid, fillLevel);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_overflow_clear();
    // overflow still set from the previous scenario
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_alone: ovf=%b, want 0", overflow);
    end
    stReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sigIn = 8'h50 + 8'(i); sigInValid = 1'b1;
      step();
    end
    sigIn = 8'h5F; clearOverflow = 1'b1;
    step();
    sigInValid = 1'b0; clearOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || fillLevel !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b fill=%0d, want 1/4", overflow, fillLevel);
    end
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_again: ovf=%b, want 0", overflow);
    end
    stReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (stData !== 8'h50 + 8'(k)) begin
        errors++;
        $display("FAIL ovf_drain %0d: data=%h, want %h", k, stData, 8'h50 + 8'(k));
      end
      step();
    end
    $display("test_overflow_clear done");
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_out [12];
    exp_out = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h10, 8'h11, 8'h12, 8'h13,
                8'h14, 8'h15, 8'h16, 8'h17};
    stReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sigIn = 8'hA0 + 8'(i); sigInValid = 1'b1;
      step();
    end
    stReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sigIn = 8'h10 + 8'(i); sigInValid = 1'b1;
      checks++;
      if (stValid !== 1'b1 || stData !== exp_out[i]) begin
        errors++;
        $display("FAIL full_rw_out %0d: stValid=%b data=%h, want 1/%h", i, stValid, stData, exp_out[i]);
      end
      step();
      checks++;
      if (fillLevel !== 3'd4 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL full_rw_level %0d: fill=%0d ovf=%b, want 4/0", i, fillLevel, overflow);
      end
    end
    sigInValid = 1'b0;
    for (int i = 8; i < 12; i++) begin
      checks++;
      if (stValid !== 1'b1 || stData !== exp_out[i]) begin
        errors++;
        $display("FAIL full_rw_tail %0d: stValid=%b data=%h, want 1/%h", i, stValid, stData, exp_out[i]);
      end
      step();
    end
    checks++;
    if (stValid !== 1'b0) begin
      errors++;
      $display("FAIL full_rw_empty: stValid=%b, want 0", stValid);
    end
    $display("test_full_rw done");
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] q[$];
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic rdy;
    logic vld;
    while (recv < 20 && cyc < 400) begin
      rdy = 1'($urandom_range(0, 1));
      vld = (sent < 20) && (q.size() < 4 || (rdy && q.size() > 0));
      stReady = rdy; sigInValid = vld; sigIn = 8'h30 + 8'(sent);
      if (rdy && q.size() > 0) begin
        checks++;
        if (stValid !== 1'b1 || stData !== q[0]) begin
          errors++;
          $display("FAIL wrap_data %0d: stValid=%b data=%h, want 1/%h", recv, stValid, stData, q[0]);
        end
        void'(q.pop_front());
        recv++;
      end
      if (vld) begin
        q.push_back(8'h30 + 8'(sent));
        sent++;
      end
      step();
      cyc++;
      checks++;
      if (fillLevel !== 3'(q.size())) begin
        errors++;
        $display("FAIL wrap_fill cyc%0d: fill=%0d, want %0d", cyc, fillLevel, q.size());
      end
    end
    checks++;
    if (recv != 20) begin
      errors++;
      $display("FAIL wrap_timeout: received %0d words, want 20", recv);
    end
    sigInValid = 1'b0; stReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sigIn = 8'hC1 + 8'(i); sigInValid = 1'b1;
      step();
    end
    sigInValid = 1'b0;
    checks++;
    if (fillLevel !== 3'd3) begin
      errors++;
      $display("FAIL prereset_fill: fill=%0d, want 3", fillLevel);
    end
    reset = 1'b0;
    step();
    checks++;
    if (fillLevel !== 3'd0 || stValid !== 1'b0) begin
      errors++;
      $display("FAIL midreset: fill=%0d stValid=%b, want 0/0", fillLevel, stValid);
    end
    reset = 1'b1;
    step();
    checks++;
    if (stValid !== 1'b0 || stData !== 8'h00) begin
      errors++;
      $display("FAIL postreset_idle: stValid=%b data=%h, want 0/00", stValid, stData);
    end
    sigIn = 8'hD1; sigInValid = 1'b1;
    step();
    sigInValid = 1'b0;
    checks++;
    if (stValid !== 1'b1 || stData !== 8'hD1 || fillLevel !== 3'd1) begin
      errors++;
      $display("FAIL postreset_fresh: stValid=%b data=%h fill=%0d, want 1/d1/1", stValid, stData, fillLevel);
    end
    stReady = 1'b1;
    step();
    checks++;
    if (stValid !== 1'b0) begin
      errors++;
      $display("FAIL postreset_stale: stValid=%b data=%h, want empty", stValid, stData);
    end
    $display("test_wrap_and_reset done");
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; sigIn = '0; sigInValid = 1'b0; clearOverflow = 1'b0; stReady = 1'b0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow_clear();
    test_full_rw();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
